// File: rtl/trdb_pkg.sv
// Shared types and layout constants for the trace packet decoder.
// Minimum-length constants are only consulted when TRDB_DEC_LENGTH_CHECK_EN is defined.
package trdb_pkg;

  typedef enum logic [1:0] {
    FMT_UNSUPPORTED = 2'd0,
    FMT_BRANCH      = 2'd1,
    FMT_ADDR        = 2'd2,
    FMT_SYNC        = 2'd3
  } format_e;

  typedef enum logic [1:0] {
    SF_START     = 2'd0,
    SF_EXCEPTION = 2'd1,
    SF_CONTEXT   = 2'd2,
    SF_SUPPORT   = 2'd3
  } subformat_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  localparam int MAP_LSB   = 7;
  localparam int MAP_MAX_W = 31;

  // Decoded bit counts per layout; the address-bearing ones add XLEN on top.
  localparam int SYNC_START_BITS = 7;
  localparam int SYNC_EXC_BITS   = 45;
  localparam int SYNC_CTX_BITS   = 6;
  localparam int SYNC_SUP_BITS   = 11;
  localparam int ADDR_FMT_BITS   = 4;
  localparam int BRANCH_HDR_BITS = 7;

  function automatic logic [4:0] mapWidth(input logic [4:0] branches);
    if (branches == 5'd0)       return 5'd31;
    else if (branches == 5'd1)  return 5'd1;
    else if (branches <= 5'd9)  return 5'd9;
    else if (branches <= 5'd17) return 5'd17;
    else if (branches <= 5'd25) return 5'd25;
    else                        return 5'd31;
  endfunction

  function automatic int minLengthBytes(input logic [1:0] fmt, input logic [1:0] sf,
                                        input logic [4:0] branches, input int xlen);
    int bits;
    bits = 0;
    case (fmt)
      FMT_SYNC: begin
        case (sf)
          SF_START:     bits = SYNC_START_BITS + xlen;
          SF_EXCEPTION: bits = SYNC_EXC_BITS + xlen;
          SF_CONTEXT:   bits = SYNC_CTX_BITS;
          default:      bits = SYNC_SUP_BITS;
        endcase
      end
      FMT_ADDR:   bits = ADDR_FMT_BITS + xlen;
      FMT_BRANCH: bits = BRANCH_HDR_BITS + int'(mapWidth(branches)) + ((branches != 5'd0) ? xlen : 0);
      default:    bits = 0;
    endcase
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/trdb_branch_serializer.sv
// Streams a format-1 branch map one outcome per handshake, oldest (bit 0) first.
module trdb_branch_serializer
  import trdb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [MAP_MAX_W-1:0] map_i,
  input  logic [4:0]           count_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic                 taken_o,
  output logic                 last_o
);

  logic [MAP_MAX_W-1:0] map_q;
  logic [4:0]           idx_q;
  logic [4:0]           lastIdx_q;
  logic                 valid_q;

  // count_i is always 1..31, so lastIdx_q never exceeds 30.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      map_q     <= '0;
      idx_q     <= '0;
      lastIdx_q <= '0;
      valid_q   <= 1'b0;
    end else if (load_i) begin
      map_q     <= map_i;
      idx_q     <= '0;
      lastIdx_q <= 5'(count_i - 5'd1);
      valid_q   <= 1'b1;
    end else if (valid_q && ready_i) begin
      if (idx_q == lastIdx_q) valid_q <= 1'b0;
      else                    idx_q   <= 5'(idx_q + 5'd1);
    end
  end

  assign valid_o = valid_q;
  assign taken_o = valid_q & ~map_q[idx_q];
  assign last_o  = valid_q && (idx_q == lastIdx_q);

endmodule

// File: rtl/trdb_packet_decoder.sv
// Trace packet decoder: accepts one payload, streams format-1 branch outcomes, then presents fields.
// Optional TRDB_DEC_LENGTH_CHECK_EN drops packets whose byte length is shorter than their layout.
module trdb_packet_decoder
  import trdb_pkg::*;
#(
  parameter int PAYLOAD_W = 256,
  parameter int XLEN      = 32
)(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 packet_valid_i,
  output logic                 packet_ready_o,
  input  logic [PAYLOAD_W-1:0] packet_payload_i,
  input  logic [4:0]           payload_length_i,
  output logic                 br_valid_o,
  output logic                 br_taken_o,
  output logic                 br_last_o,
  input  logic                 br_ready_i,
  output logic                 pkt_valid_o,
  input  logic                 pkt_ready_i,
  output logic [1:0]           format_o,
  output logic [1:0]           subformat_o,
  output logic                 has_addr_o,
  output logic [XLEN-1:0]      address_o,
  output logic                 branch_o,
  output logic [1:0]           priv_o,
  output logic [4:0]           ecause_o,
  output logic                 interrupt_o,
  output logic [XLEN-1:0]      tval_o,
  output logic                 notify_o,
  output logic                 updiscon_o,
  output logic                 ienable_o,
  output logic                 encoder_mode_o,
  output logic [1:0]           qual_status_o,
  output logic [2:0]           ioptions_o,
  output logic                 err_o
);

  // Highest decoded bit is the top of the exception tval field.
  localparam int DEC_W = SYNC_EXC_BITS + XLEN;

  state_e           state_q;
  logic [DEC_W-1:0] payload_q;
  logic             err_q;

  logic [1:0] fmtIn;
  logic [4:0] branchesIn;
  logic       accept;
  logic       lengthShort;
  logic       dropIn;
  logic       brHandshakeLast;

  assign fmtIn      = packet_payload_i[1:0];
  assign branchesIn = packet_payload_i[6:2];
  assign accept     = packet_valid_i && (state_q == ST_IDLE);

`ifdef TRDB_DEC_LENGTH_CHECK_EN
  assign lengthShort = int'(payload_length_i) <
                       minLengthBytes(fmtIn, packet_payload_i[3:2], branchesIn, XLEN);
`else
  assign lengthShort = 1'b0;
`endif

  assign dropIn = (fmtIn == FMT_UNSUPPORTED) || lengthShort;

  trdb_branch_serializer u_serializer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (accept && !dropIn && (fmtIn == FMT_BRANCH)),
    .map_i   (packet_payload_i[MAP_LSB +: MAP_MAX_W]),
    .count_i ((branchesIn == 5'd0) ? 5'd31 : branchesIn),
    .ready_i (br_ready_i),
    .valid_o (br_valid_o),
    .taken_o (br_taken_o),
    .last_o  (br_last_o)
  );

  assign brHandshakeLast = br_valid_o && br_ready_i && br_last_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      payload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (dropIn) begin
              err_q <= 1'b1;
            end else begin
              payload_q <= packet_payload_i[DEC_W-1:0];
              state_q   <= (fmtIn == FMT_BRANCH) ? ST_DRAIN : ST_EMIT;
            end
          end
        end
        ST_DRAIN: if (brHandshakeLast) state_q <= ST_EMIT;
        ST_EMIT:  if (pkt_ready_i)     state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign packet_ready_o = (state_q == ST_IDLE);
  assign pkt_valid_o    = (state_q == ST_EMIT);
  assign err_o          = err_q;

  // Format-1 address sits directly above a map whose width depends on the branch count.
  logic [4:0]       f1Width;
  logic [DEC_W-1:0] f1Shifted;
  assign f1Width   = mapWidth(payload_q[6:2]);
  assign f1Shifted = payload_q >> (MAP_LSB + int'(f1Width));

  always_comb begin
    format_o       = payload_q[1:0];
    subformat_o    = 2'd0;
    has_addr_o     = 1'b0;
    address_o      = '0;
    branch_o       = 1'b0;
    priv_o         = 2'd0;
    ecause_o       = 5'd0;
    interrupt_o    = 1'b0;
    tval_o         = '0;
    notify_o       = 1'b0;
    updiscon_o     = 1'b0;
    ienable_o      = 1'b0;
    encoder_mode_o = 1'b0;
    qual_status_o  = 2'd0;
    ioptions_o     = 3'd0;
    case (format_e'(payload_q[1:0]))
      FMT_SYNC: begin
        subformat_o = payload_q[3:2];
        case (subformat_e'(payload_q[3:2]))
          SF_START, SF_EXCEPTION: begin
            has_addr_o = 1'b1;
            branch_o   = payload_q[4];
            priv_o     = payload_q[6:5];
            address_o  = payload_q[7 +: XLEN];
            if (payload_q[3:2] == SF_EXCEPTION) begin
              ecause_o    = payload_q[7+XLEN +: 5];
              interrupt_o = payload_q[12+XLEN];
              tval_o      = payload_q[13+XLEN +: XLEN];
            end
          end
          SF_CONTEXT: priv_o = payload_q[5:4];
          SF_SUPPORT: begin
            ienable_o      = payload_q[4];
            encoder_mode_o = payload_q[5];
            qual_status_o  = payload_q[7:6];
            ioptions_o     = payload_q[10:8];
          end
        endcase
      end
      FMT_ADDR: begin
        has_addr_o = 1'b1;
        address_o  = payload_q[2 +: XLEN];
        notify_o   = payload_q[2+XLEN];
        updiscon_o = payload_q[3+XLEN];
      end
      FMT_BRANCH: begin
        if (payload_q[6:2] != 5'd0) begin
          has_addr_o = 1'b1;
          address_o  = f1Shifted[XLEN-1:0];
        end
      end
      FMT_UNSUPPORTED: ;
    endcase
  end

endmodule

// File: tb/tb_trdb_packet_decoder.sv
// Self-checking bench for trdb_packet_decoder: vector table plus scoreboard queues.
module tb_trdb_packet_decoder;

  localparam int PAYLOAD_W = 256;
  localparam int XLEN      = 32;
`ifdef TRDB_DEC_LENGTH_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  fmt;
    logic [1:0]  sf;
    logic        hasAddr;
    logic [31:0] addr;
    logic        branch;
    logic [1:0]  priv;
    logic [4:0]  ecause;
    logic        intr;
    logic [31:0] tval;
    logic        notify;
    logic        updiscon;
    logic        ienable;
    logic        mode;
    logic [1:0]  qual;
    logic [2:0]  iopt;
  } pkt_t;

  typedef struct {
    string                name;
    logic [PAYLOAD_W-1:0] payload;
    logic [4:0]           len;
    bit                   expErr;
    int                   brCount;
    logic [30:0]          brTaken;
    pkt_t                 exp;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 packet_valid_i;
  logic                 packet_ready_o;
  logic [PAYLOAD_W-1:0] packet_payload_i;
  logic [4:0]           payload_length_i;
  logic                 br_valid_o, br_taken_o, br_last_o, br_ready_i;
  logic                 pkt_valid_o, pkt_ready_i;
  logic [1:0]           format_o, subformat_o, priv_o, qual_status_o;
  logic                 has_addr_o, branch_o, interrupt_o, notify_o, updiscon_o;
  logic                 ienable_o, encoder_mode_o, err_o;
  logic [XLEN-1:0]      address_o, tval_o;
  logic [4:0]           ecause_o;
  logic [2:0]           ioptions_o;

  always #5 clk = ~clk;

  trdb_packet_decoder #(.PAYLOAD_W(PAYLOAD_W), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .packet_valid_i(packet_valid_i), .packet_ready_o(packet_ready_o),
    .packet_payload_i(packet_payload_i), .payload_length_i(payload_length_i),
    .br_valid_o(br_valid_o), .br_taken_o(br_taken_o), .br_last_o(br_last_o),
    .br_ready_i(br_ready_i),
    .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .format_o(format_o), .subformat_o(subformat_o), .has_addr_o(has_addr_o),
    .address_o(address_o), .branch_o(branch_o), .priv_o(priv_o),
    .ecause_o(ecause_o), .interrupt_o(interrupt_o), .tval_o(tval_o),
    .notify_o(notify_o), .updiscon_o(updiscon_o), .ienable_o(ienable_o),
    .encoder_mode_o(encoder_mode_o), .qual_status_o(qual_status_o),
    .ioptions_o(ioptions_o), .err_o(err_o)
  );

  pkt_t dutPkt;
  assign dutPkt = {format_o, subformat_o, has_addr_o, address_o, branch_o, priv_o,
                   ecause_o, interrupt_o, tval_o, notify_o, updiscon_o, ienable_o,
                   encoder_mode_o, qual_status_o, ioptions_o};

  int         checks = 0;
  int         errors = 0;
  pkt_t       pktQ[$];
  logic [1:0] brQ[$];
  vec_t       vecs[$];
  pkt_t       pktExp;
  logic [1:0] brExp;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: a beat or packet is consumed at the next posedge when valid and ready are high.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (br_valid_o && br_ready_i) begin
        if (brQ.size() == 0) checkOutput("unexpected_beat", 128'(1), 128'(0));
        else begin
          brExp = brQ.pop_front();
          checkOutput("beat", 128'({br_taken_o, br_last_o}), 128'(brExp));
        end
      end
      if (pkt_valid_o && pkt_ready_i) begin
        if (pktQ.size() == 0) checkOutput("unexpected_pkt", 128'(1), 128'(0));
        else begin
          pktExp = pktQ.pop_front();
          checkOutput("pkt_fields", 128'(dutPkt), 128'(pktExp));
        end
      end
    end
  end

  function automatic logic [PAYLOAD_W-1:0] f3s0(logic b, logic [1:0] pr, logic [31:0] a);
    logic [PAYLOAD_W-1:0] p;
    p = '0; p[1:0] = 2'd3; p[4] = b; p[6:5] = pr; p[38:7] = a;
    return p;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] f3s1(logic b, logic [1:0] pr, logic [31:0] a,
                                               logic [4:0] ec, logic irq, logic [31:0] tv);
    logic [PAYLOAD_W-1:0] p;
    p = f3s0(b, pr, a); p[3:2] = 2'd1; p[43:39] = ec; p[44] = irq; p[76:45] = tv;
    return p;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] f3s2(logic [1:0] pr);
    logic [PAYLOAD_W-1:0] p;
    p = '0; p[1:0] = 2'd3; p[3:2] = 2'd2; p[5:4] = pr;
    return p;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] f3s3(logic ien, logic md, logic [1:0] q, logic [2:0] io);
    logic [PAYLOAD_W-1:0] p;
    p = '0; p[1:0] = 2'd3; p[3:2] = 2'd3; p[4] = ien; p[5] = md; p[7:6] = q; p[10:8] = io;
    return p;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] f2(logic [31:0] a, logic nt, logic ud);
    logic [PAYLOAD_W-1:0] p;
    p = '0; p[1:0] = 2'd2; p[33:2] = a; p[34] = nt; p[35] = ud;
    return p;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] f1(logic [4:0] n, int w, logic [30:0] map, logic [31:0] a);
    logic [PAYLOAD_W-1:0] p;
    p = '0; p[1:0] = 2'd1; p[6:2] = n; p[37:7] = map;
    p = p | (PAYLOAD_W'(a) << (7 + w));
    return p;
  endfunction

  function automatic pkt_t mkPkt(logic [1:0] fmt, logic [1:0] sf, logic has, logic [31:0] a);
    pkt_t e;
    e = '0; e.fmt = fmt; e.sf = sf; e.hasAddr = has; e.addr = a;
    return e;
  endfunction

  function automatic vec_t mkVec(string name, logic [PAYLOAD_W-1:0] p, logic [4:0] len, bit err,
                                 int cnt, logic [30:0] tk, pkt_t e);
    vec_t v;
    v.name = name; v.payload = p; v.len = len; v.expErr = err;
    v.brCount = cnt; v.brTaken = tk; v.exp = e;
    return v;
  endfunction

  task automatic drivePacket(input logic [PAYLOAD_W-1:0] p, input logic [4:0] len, output bit accepted);
    int n;
    @(posedge clk); #1;
    packet_valid_i = 1'b1; packet_payload_i = p; payload_length_i = len;
    n = 0;
    @(negedge clk);
    while (!packet_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    accepted = packet_ready_o;
    @(posedge clk); #1;
    packet_valid_i = 1'b0; packet_payload_i = '0; payload_length_i = 5'd0;
    if (!accepted) checkOutput("accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic waitEmpty(input string name);
    int n;
    n = 0;
    while ((brQ.size() != 0 || pktQ.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (brQ.size() != 0 || pktQ.size() != 0) begin
      checkOutput({name, "_timeout"}, 128'(brQ.size() + pktQ.size()), 128'(0));
      brQ.delete();
      pktQ.delete();
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bit acc;
    if (!v.expErr) begin
      for (int i = 0; i < v.brCount; i++) brQ.push_back({v.brTaken[i], (i == v.brCount - 1)});
      pktQ.push_back(v.exp);
    end
    drivePacket(v.payload, v.len, acc);
    if (!acc) begin
      brQ.delete();
      pktQ.delete();
      return;
    end
    @(negedge clk);
    if (v.expErr)
      checkOutput({v.name, "_err"}, 128'({err_o, br_valid_o, pkt_valid_o}), 128'(3'b100));
    else
      checkOutput({v.name, "_latency"}, 128'({err_o, br_valid_o, pkt_valid_o}),
                  128'({1'b0, v.brCount != 0, v.brCount == 0}));
    waitEmpty(v.name);
  endtask

  initial begin
    pkt_t e;
    bit   acc;
    rst_i = 1'b1; packet_valid_i = 1'b0; packet_payload_i = '0; payload_length_i = 5'd0;
    br_ready_i = 1'b1; pkt_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_fields", 128'(dutPkt), 128'(0));
    checkOutput("reset_flags", 128'({br_valid_o, pkt_valid_o, err_o}), 128'(0));
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 128'(packet_ready_o), 128'(1));

    e = mkPkt(3, 0, 1, 32'h8000_0000); e.branch = 1; e.priv = 3;
    vecs.push_back(mkVec("f3_sf0", f3s0(1, 3, 32'h8000_0000), 5, 0, 0, 0, e));
    e = mkPkt(3, 1, 1, 32'h1234_5678); e.priv = 1; e.ecause = 5'h1B; e.intr = 1; e.tval = 32'hDEAD_BEEF;
    vecs.push_back(mkVec("f3_sf1", f3s1(0, 1, 32'h1234_5678, 5'h1B, 1, 32'hDEAD_BEEF), 10, 0, 0, 0, e));
    e = mkPkt(3, 2, 0, 0); e.priv = 2;
    vecs.push_back(mkVec("f3_sf2", f3s2(2), 1, 0, 0, 0, e));
    e = mkPkt(3, 3, 0, 0); e.ienable = 1; e.qual = 2; e.iopt = 5;
    vecs.push_back(mkVec("f3_sf3", f3s3(1, 0, 2, 5), 2, 0, 0, 0, e));
    e = mkPkt(2, 0, 1, 32'hCAFE_0004); e.notify = 1;
    vecs.push_back(mkVec("f2", f2(32'hCAFE_0004, 1, 0), 5, 0, 0, 0, e));
    e = mkPkt(1, 0, 1, 32'h100);
    vecs.push_back(mkVec("f1_n3", f1(3, 9, 31'h2, 32'h100), 6, 0, 3, 31'h5, e));
    e = mkPkt(1, 0, 0, 0);
    vecs.push_back(mkVec("f1_n0", f1(0, 31, 31'h0, 0), 5, 0, 31, 31'h7FFF_FFFF, e));
    e = mkPkt(1, 0, 1, 32'hFFFF_FFFF);
    vecs.push_back(mkVec("f1_n1", f1(1, 1, 31'h1, 32'hFFFF_FFFF), 5, 0, 1, 31'h0, e));
    e = mkPkt(1, 0, 1, 32'h0000_BEEF);
    vecs.push_back(mkVec("f1_n20", f1(20, 25, 31'h1F5_5555, 32'h0000_BEEF), 8, 0, 20, 31'hA_AAAA, e));
    e = mkPkt(1, 0, 1, 32'h1);
    vecs.push_back(mkVec("f1_n31", f1(31, 31, 31'h7FFF_0000, 32'h1), 9, 0, 31, 31'h0000_FFFF, e));
    e = '0;
    vecs.push_back(mkVec("fmt0", PAYLOAD_W'(8'hF0), 4, 1, 0, 0, e));
    e = mkPkt(3, 1, 1, 32'h0BAD_F00D); e.branch = 1; e.priv = 2; e.ecause = 5'h02; e.tval = 32'h55AA_55AA;
    vecs.push_back(mkVec("f3_sf1_short", f3s1(1, 2, 32'h0BAD_F00D, 5'h02, 0, 32'h55AA_55AA), 9, LEN_CHECK, 0, 0, e));
    e = mkPkt(1, 0, 1, 32'h00AB_CDEF);
    vecs.push_back(mkVec("f1_n10_short", f1(10, 17, 31'h1_0201, 32'h00AB_CDEF), 6, LEN_CHECK, 10, 31'h1FE, e));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Branch stream stalled: the first outcome must hold for four extra cycles.
    br_ready_i = 1'b0;
    brQ.push_back(2'b10); brQ.push_back(2'b00); brQ.push_back(2'b11);
    pktQ.push_back(mkPkt(1, 0, 1, 32'h100));
    drivePacket(f1(3, 9, 31'h2, 32'h100), 6, acc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("br_stall_hold", 128'({br_valid_o, br_taken_o, br_last_o, pkt_valid_o}), 128'(4'b1100));
    end
    @(posedge clk); #1 br_ready_i = 1'b1;
    waitEmpty("br_stall");

    // Packet consumer stalled: fields stable and no new packet accepted.
    pkt_ready_i = 1'b0;
    e = mkPkt(2, 0, 1, 32'h0000_0FF0); e.updiscon = 1;
    pktQ.push_back(e);
    drivePacket(f2(32'h0000_0FF0, 0, 1), 5, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("pkt_stall_hold", 128'({pkt_valid_o, packet_ready_o, dutPkt}), 128'({1'b1, 1'b0, e}));
    end
    @(posedge clk); #1 pkt_ready_i = 1'b1;
    waitEmpty("pkt_stall");

    // Reset while draining drops the packet.
    br_ready_i = 1'b0;
    drivePacket(f1(0, 31, 31'h0, 0), 5, acc);
    @(negedge clk);
    checkOutput("drain_before_reset", 128'(br_valid_o), 128'(1));
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("after_reset_mid_drain", 128'({br_valid_o, pkt_valid_o, packet_ready_o, err_o}), 128'(4'b0010));
    br_ready_i = 1'b1;
    applyStimulus(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
